// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the lockable arbiter.
// Holds the FSM state encoding and the grant index encoder.
package arbiter_pkg;

    localparam int ARB_MAX_REQ = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    function automatic logic [4:0] onehot_to_bin(
        input logic [ARB_MAX_REQ-1:0] oh
    );
        logic [4:0] b;
        b = '0;
        for (int i = 0; i < ARB_MAX_REQ; i++) begin
            if (oh[i]) b = b | 5'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// Combinational fixed-priority pick: lowest set request bit wins.
// Used twice by the lockable arbiter (masked and unmasked vectors).
module fixed_priority_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign gnt_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/lockable_rr_arbiter.sv
// Registered N-way arbiter with packet locking, round-robin or fixed
// priority selection, and a hold timeout while others are waiting.
module lockable_rr_arbiter
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         last_i,
    input  logic                       ready_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int HW    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HLI   = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HW-1:0] HOLD_LAST = HLI[HW-1:0];
    localparam logic [HW-1:0] HOLD_MAX  = MAX_HOLD[HW-1:0];
    localparam logic [NUM_REQ-1:0] PTR_RST = {1'b1, {(NUM_REQ-1){1'b0}}};

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;

    logic               busy;
    logic               others;
    logic               beat;
    logic               is_last;
    logic               timeout;
    logic               release_w;
    logic [NUM_REQ-1:0] ptr_eff;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] win_m;
    logic [NUM_REQ-1:0] win_u;
    logic [NUM_REQ-1:0] winner;

    assign busy      = (state_q == ARB_LOCKED);
    assign others    = |(req_i & ~gnt_q);
    assign beat      = busy & (|(req_i & gnt_q)) & ready_i;
    assign is_last   = |(last_i & gnt_q);
    assign timeout   = (MAX_HOLD > 0) && busy && others
                       && (hold_q == HOLD_LAST);
    assign release_w = busy & ((beat & is_last) | timeout);

    // On release the pointer moves to the owner in the same cycle,
    // and the owner is excluded so it cannot win its own release.
    assign ptr_eff = ((RR_EN != 0) && release_w) ? gnt_q : ptr_q;
    assign cand    = busy ? (req_i & ~gnt_q) : req_i;
    assign mask    = (RR_EN != 0)
                     ? ~(ptr_eff | (ptr_eff - NUM_REQ'(1))) : '0;

    fixed_priority_arbiter #(.N(NUM_REQ)) u_fpa_masked (
        .req_i (cand & mask),
        .gnt_o (win_m)
    );

    fixed_priority_arbiter #(.N(NUM_REQ)) u_fpa_plain (
        .req_i (cand),
        .gnt_o (win_u)
    );

    assign winner = (|win_m) ? win_m : win_u;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req_i) begin
                    state_d = ARB_LOCKED;
                    gnt_d   = winner;
                    hold_d  = '0;
                end
            end
            ARB_LOCKED: begin
                if (release_w) begin
                    if (RR_EN != 0) ptr_d = gnt_q;
                    hold_d = '0;
                    if (|cand) begin
                        gnt_d = winner;
                    end else begin
                        gnt_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end else if ((MAX_HOLD > 0) && others
                             && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_RST;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = busy;
    assign gnt_idx_o = IDX_W'(onehot_to_bin(ARB_MAX_REQ'(gnt_q)));

    a_onehot: assert property (
        @(posedge clk_i) disable iff (!arst_ni) $onehot0(gnt_q)
    );

    a_stable: assert property (
        @(posedge clk_i) disable iff (!arst_ni)
        (busy && !release_w) |=> $stable(gnt_q)
    );

endmodule

// File: tb/tb_lockable_rr_arbiter.sv
// Scoreboard bench: three arbiter configurations share one stimulus
// stream and are compared against an integer-level reference model.
module tb_lockable_rr_arbiter;

    logic       clk = 1'b0;
    logic       arst_ni = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] lst = '0;
    logic       rdy = 1'b0;

    logic [3:0] gnt_w  [3];
    logic [1:0] idx_w  [3];
    logic       busy_w [3];

    always #5 clk = ~clk;

    lockable_rr_arbiter #(.NUM_REQ(4), .RR_EN(1), .MAX_HOLD(16)) u0 (
        .clk_i(clk), .arst_ni(arst_ni), .req_i(req), .last_i(lst),
        .ready_i(rdy), .gnt_o(gnt_w[0]), .gnt_idx_o(idx_w[0]),
        .busy_o(busy_w[0])
    );

    lockable_rr_arbiter #(.NUM_REQ(4), .RR_EN(0), .MAX_HOLD(4)) u1 (
        .clk_i(clk), .arst_ni(arst_ni), .req_i(req), .last_i(lst),
        .ready_i(rdy), .gnt_o(gnt_w[1]), .gnt_idx_o(idx_w[1]),
        .busy_o(busy_w[1])
    );

    lockable_rr_arbiter #(.NUM_REQ(4), .RR_EN(1), .MAX_HOLD(0)) u2 (
        .clk_i(clk), .arst_ni(arst_ni), .req_i(req), .last_i(lst),
        .ready_i(rdy), .gnt_o(gnt_w[2]), .gnt_idx_o(idx_w[2]),
        .busy_o(busy_w[2])
    );

    typedef struct packed {
        logic [2:0][3:0] g;
        logic [2:0]      b;
        logic [2:0][1:0] ix;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    int rrp [3] = '{1, 0, 1};
    int mhp [3] = '{16, 4, 0};
    int own [3];
    int lown[3];
    int hold[3];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Round-robin: first requester after the last owner, cyclically.
    function automatic int pick(input logic [3:0] r, input int last,
                                input int rr);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (rr != 0) ? (last + k) % 4 : k - 1;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            own[i]  = -1;
            lown[i] = 3;
            hold[i] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] l,
                              input logic rd);
        for (int i = 0; i < 3; i++) begin
            if (own[i] < 0) begin
                if (r != 0) begin
                    own[i]  = pick(r, lown[i], rrp[i]);
                    hold[i] = 0;
                end
            end else begin
                logic [3:0] c;
                bit oth, rel;
                c   = r & ~(4'b0001 << own[i]);
                oth = (c != 0);
                rel = (r[own[i]] && rd && l[own[i]])
                      || (mhp[i] > 0 && oth && hold[i] == mhp[i] - 1);
                if (rel) begin
                    if (rrp[i] != 0) lown[i] = own[i];
                    own[i]  = pick(c, lown[i], rrp[i]);
                    hold[i] = 0;
                end else if (mhp[i] > 0 && oth && hold[i] < mhp[i]) begin
                    hold[i]++;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l,
                        input logic rd);
        exp_t e;
        @(negedge clk);
        req = r;
        lst = l;
        rdy = rd;
        model_step(r, l, rd);
        for (int i = 0; i < 3; i++) begin
            e.g[i]  = (own[i] >= 0) ? 4'(1 << own[i]) : 4'd0;
            e.b[i]  = (own[i] >= 0);
            e.ix[i] = (own[i] >= 0) ? 2'(own[i]) : 2'd0;
        end
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        lst = '0;
        rdy = 1'b0;
        arst_ni = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_gnt%0d", i), int'(gnt_w[i]), 0);
            chk($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
            chk($sformatf("rst_idx%0d", i), int'(idx_w[i]), 0);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        arst_ni = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("sb_gnt%0d", i), int'(gnt_w[i]),
                        int'(e.g[i]));
                    chk($sformatf("sb_busy%0d", i), int'(busy_w[i]),
                        int'(e.b[i]));
                    if (e.b[i])
                        chk($sformatf("sb_idx%0d", i), int'(idx_w[i]),
                            int'(e.ix[i]));
                end
            end
        end
    end

    initial begin : stim
        model_reset();
        do_reset();

        // Single grant from IDLE, one cycle latency.
        step(4'b0110, 4'b0000, 1'b1);
        settle();
        chk("t1_gnt", int'(gnt_w[0]), 2);
        chk("t1_busy", int'(busy_w[0]), 1);
        chk("t1_idx", int'(idx_w[0]), 1);

        // Back-to-back 2-beat packets, all requesting.
        do_reset();
        step(4'b1111, 4'b0000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("t2_rr%0d", k), int'(gnt_w[0]), 1 << (k % 4));
            chk($sformatf("t3_fp%0d", k), int'(gnt_w[1]),
                (k % 2 != 0) ? 2 : 1);
            step(4'b1111, 4'b0000, 1'b1);
            step(4'b1111, 4'b1111, 1'b1);
        end

        // Hold timeout while requester 0 waits.
        do_reset();
        step(4'b0100, 4'b0000, 1'b1);
        repeat (4) step(4'b0101, 4'b0000, 1'b1);
        settle();
        chk("t4_timeout", int'(gnt_w[1]), 1);
        chk("t4_nolimit", int'(gnt_w[0]), 4);

        // Unlimited hold with ready low and owner request dropped.
        do_reset();
        step(4'b0010, 4'b0000, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(4'b0001, 4'b0000, 1'b0);
            settle();
            chk($sformatf("t5_hold%0d", k), int'(gnt_w[2]), 2);
        end
        step(4'b0011, 4'b0010, 1'b1);
        settle();
        chk("t5_release", int'(gnt_w[2]), 1);

        // Reset mid-packet after the pointer has moved.
        do_reset();
        step(4'b1111, 4'b0000, 1'b1);
        step(4'b1111, 4'b1111, 1'b1);
        step(4'b1111, 4'b1111, 1'b1);
        step(4'b1111, 4'b0000, 1'b1);
        do_reset();
        step(4'b1111, 4'b0000, 1'b1);
        settle();
        chk("t6_rr0", int'(gnt_w[0]), 1);
        chk("t6_rr2", int'(gnt_w[2]), 1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                     ($urandom_range(0, 3) != 0));
            end
        end

        settle();
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
